// File: rtl/uart_pkg.sv
// Shared definitions for the 8E1 UART transmit/receive pair.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 5208;   // 50 MHz / 9600 baud, truncated

    // Line state of one frame: start, eight data bits, parity, stop.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO buffering pushes ahead of the UART shifter.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 pop_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 ready_o,
    output logic                 empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic                 push_ok;
    logic                 pop_ok;

    // Ready depends only on registered occupancy, so a pop in the same
    // cycle never makes a push into a full FIFO acceptable.
    assign ready_o = (count_q < CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && ready_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; DEPTH is a power of two, so
    // the pointers wrap naturally.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state registers use non-blocking assignments so every flop samples its pre-edge inputs.
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array has no reset; occupancy decides which entries are valid, so stale contents are never read.
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits, even parity, 1 stop bit, with input FIFO.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 CLK50MHz,
    input  logic                 RESET,
    input  logic [DATA_BITS-1:0] DATA_IN,
    input  logic                 VALID,
    output logic                 READY,
    output logic                 TX,
    output logic                 BUSY
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 pop;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 bit_done;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (CLK50MHz),
        .rst_ni  (RESET),
        .push_i  (VALID),
        .data_i  (DATA_IN),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .ready_o (READY),
        .empty_o (fifo_empty)
    );

    assign bit_done = (cnt_q == CNT_LAST);
    assign TX       = tx_q;
    assign BUSY     = (state_q != ST_IDLE) || !fifo_empty;

    // Frame sequencing, baud counting, and the next line level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        sh_d    = sh_q;
        par_d   = par_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sh_d    = fifo_data;
                    par_d   = even_parity(fifo_data);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) state_d = ST_PARITY;
                    else                   idx_d   = idx_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    // Back-to-back frames: reload straight into START.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        sh_d    = fifo_data;
                        par_d   = even_parity(fifo_data);
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // The line level is registered from the next state, so TX changes
        // on the same edge as the state and never glitches.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = sh_d[idx_d];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // FSM, counters, shifter and line register; reset drives the line idle at once.
    always_ff @(posedge CLK50MHz or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-oriented UART transmitter for the DE2-115 serial path: 8 data bits, even parity, 1 stop bit (8E1), 9600 baud from the 50 MHz board clock. It produces exactly the frame format the receive side expects, so it feeds the UART RX line either to an external device or in FPGA-internal loopback. A small input FIFO lets FPGA logic push bursts of bytes without waiting on the serial line.

## Interface
Parameters:
- CLKS_PER_BIT, 5208, CLK50MHz cycles per bit (50e6/9600, truncated); sims override to 16.
- FIFO_DEPTH, 4, input FIFO entries; power of two, minimum 2.

Ports:
- CLK50MHz  input  1  system clock; all logic on its rising edge.
- RESET  input  1  reset, asynchronous and active-low.
- DATA_IN  input  8  byte to send; DATA_IN[0] goes on the line first.
- VALID  input  1  DATA_IN holds a byte to enqueue.
- READY  output  1  FIFO can accept a byte; high when occupancy < FIFO_DEPTH.
- TX  output  1  serial line; idle high.
- BUSY  output  1  high while a frame is on the line or the FIFO is non-empty.

## Operation
- Push: at a rising edge where VALID and READY are both high, DATA_IN is written to the FIFO tail. VALID while READY is low is ignored and nothing is stored.
- READY is combinational from registered occupancy. A push and a pop in the same cycle leave occupancy unchanged. When the FIFO is full, a pop in the same cycle does not make that cycle's push acceptable.
- FSM states:
  - IDLE: TX=1. If the FIFO is non-empty, pop the head into shift register sh, compute par = ^sh (even parity), and go to START.
  - START: TX=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: TX=sh[idx] for CLKS_PER_BIT cycles per bit. After idx 7, go to PARITY.
  - PARITY: TX=par for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no extra idle cycle); otherwise go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). It clears on every state or bit change and counts 0..CLKS_PER_BIT-1.
- TX is driven from a register (glitch-free).
- BUSY = (state != IDLE) | (occupancy != 0).
- Reset values: TX=1, BUSY=0, READY=1, FIFO empty, state IDLE, all counters 0.
- Reset asserted mid-frame: TX goes to 1 immediately and asynchronously. The frame in progress and the FIFO contents are discarded, with no partial retransmit after release.

## Timing
- Latency: push at edge N into an empty FIFO with state IDLE -> pop and TX falling at edge N+1.
- Frame length: exactly 11 x CLKS_PER_BIT cycles from the TX falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins at the edge immediately after the last stop-bit cycle.
- Sustained throughput: one byte per 11 x CLKS_PER_BIT cycles. A burst of up to FIFO_DEPTH+1 bytes is accepted without stalling (one byte in the shifter plus a full FIFO).
- Actual baud rate is 9600.6 (+0.006%), well inside the receiver's tolerance.

## Structure
- Shared package uart_pkg holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP),
  - DATA_BITS=8,
  - the default CLKS_PER_BIT=5208,
  - a parity function even_parity(byte) for use by both TX and RX.
- One sub-module: uart_tx_fifo, a synchronous FIFO with FIFO_DEPTH entries x 8 bits, occupancy counter, wrap-around pointers, and async active-low reset. The FSM and baud counter stay in uart_tx.

## Test plan
CLKS_PER_BIT=16 for all scenarios.
- Reset, then idle for 100 cycles -> TX=1, READY=1, BUSY=0 throughout.
- Push 0x55 -> TX falls 1 cycle later. Sampled at bit centres: 0, then 1,0,1,0,1,0,1,0, parity 0, stop 1. Total 176 cycles, then BUSY=0.
- Push 0x01, then 0xFF back-to-back -> parity 1 then 0. The second start bit begins exactly 176 cycles after the first. An RX model in loopback decodes 0x01, 0xFF.
- Hold VALID high with bytes 0x10..0x15 -> READY drops after the 5th accepted byte (0x14), and 0x15 is accepted only once READY returns. All six bytes are sent in order.
- Assert RESET at cycle 80 of a 0xA3 frame -> TX=1 immediately. After release, FIFO empty, BUSY=0, no further frame.
- Push while full with a simultaneous pop (STOP->START transition) -> byte rejected, occupancy stays at FIFO_DEPTH-1 after the pop, and no data is corrupted.
